axi4_stream_ready_sink: RTL and testbench

//  Synthesizable AXI4-Stream receiver: the slave end of a stream driven by a master VIP or RTL source.

---
 rtl/axi4_stream_ready_sink.sv | 205 ++++++++++++++++++++
 tb/tb_axi4_stream_ready_sink.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_stream_ready_sink.sv
// Purpose : AXI4-Stream sink; drives s_tready from a programmable back-pressure
//           policy (ALWAYS / OSC / SINGLE / AFTER_VALID_OSC) and checks that
//           received data follows an incrementing sequence.
// Latency : s_tready is a registered Moore output of the policy FSM (0 cycles
//           from state entry). Counters, err_flag and last_data update on the
//           clock edge that completes a handshake.
// Backpressure: this block is the only source of back-pressure. s_tready never
//           depends on the current-cycle s_tvalid.
//
// Ports:
//   aclk, areset            clock; asynchronous active-high reset (release
//                           expected synchronous to aclk)
//   s_tvalid/s_tready/s_tdata/s_tlast   AXI4-Stream slave channel
//   cfg_policy              0=ALWAYS 1=OSC 2=SINGLE 3=AFTER_VALID_OSC
//   cfg_low / cfg_high      ready-low / ready-high phase lengths in cycles
//   exp_load / exp_seed     reload expected data value, clear err_flag
//   xfer_cnt/pkt_cnt/err_cnt  saturating beat / packet / mismatch counters
//   err_flag                sticky mismatch flag
//   last_data               data of the most recent accepted beat
module axi4_stream_ready_sink #(
    parameter int DW = 8,
    parameter int CW = 16,
    parameter int TW = 8
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic          s_tvalid,
    output logic          s_tready,
    input  logic [DW-1:0] s_tdata,
    input  logic          s_tlast,
    input  logic [1:0]    cfg_policy,
    input  logic [TW-1:0] cfg_low,
    input  logic [TW-1:0] cfg_high,
    input  logic          exp_load,
    input  logic [DW-1:0] exp_seed,
    output logic [CW-1:0] xfer_cnt,
    output logic [CW-1:0] pkt_cnt,
    output logic [CW-1:0] err_cnt,
    output logic          err_flag,
    output logic [DW-1:0] last_data
);

    localparam logic [1:0] POL_ALWAYS = 2'd0;
    localparam logic [1:0] POL_OSC    = 2'd1;
    localparam logic [1:0] POL_SINGLE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2
    } state_t;

    state_t        state;
    logic [TW-1:0] ph;        // cycles remaining in the current phase, minus one
    logic [1:0]    mode;      // policy latched on entry to LOW/HIGH
    logic [DW-1:0] exp_val;

    logic          hs;
    logic          data_err;
    logic          skip_low;
    logic          avo_wait;
    logic [TW-1:0] low_ph;
    logic [TW-1:0] high_ph;

    assign hs       = s_tvalid & s_tready;
    assign data_err = hs & (s_tdata != exp_val);

    // A zero-length low phase means the LOW state is bypassed entirely.
    assign skip_low = (cfg_low == '0);
    assign low_ph   = cfg_low - 1'b1;
    // High phase lasts max(cfg_high,1) cycles.
    assign high_ph  = (cfg_high == '0) ? '0 : cfg_high - 1'b1;
    // AFTER_VALID_OSC parks in IDLE until the source shows valid.
    assign avo_wait = (cfg_policy == 2'd3) & ~s_tvalid;

    // Policy FSM; s_tready is registered alongside the state so it is high
    // exactly while the FSM sits in HIGH.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state    <= S_IDLE;
            s_tready <= 1'b0;
            ph       <= '0;
            mode     <= POL_ALWAYS;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_policy == POL_ALWAYS) begin
                        state    <= S_HIGH;
                        s_tready <= 1'b1;
                        ph       <= high_ph;
                        mode     <= cfg_policy;
                    end else if (!avo_wait) begin
                        mode <= cfg_policy;
                        if (skip_low) begin
                            state    <= S_HIGH;
                            s_tready <= 1'b1;
                            ph       <= high_ph;
                        end else begin
                            state    <= S_LOW;
                            s_tready <= 1'b0;
                            ph       <= low_ph;
                        end
                    end
                end

                S_LOW: begin
                    if (ph == '0) begin
                        state    <= S_HIGH;
                        s_tready <= 1'b1;
                        ph       <= high_ph;
                        mode     <= cfg_policy;
                    end else begin
                        ph <= ph - 1'b1;
                    end
                end

                S_HIGH: begin
                    case (mode)
                        POL_ALWAYS: begin
                            // Leaving ALWAYS restarts the policy from IDLE.
                            if (cfg_policy != POL_ALWAYS) begin
                                state    <= S_IDLE;
                                s_tready <= 1'b0;
                            end
                        end
                        POL_SINGLE: begin
                            if (hs) begin
                                mode <= cfg_policy;
                                if (skip_low) begin
                                    ph <= high_ph;
                                end else begin
                                    state    <= S_LOW;
                                    s_tready <= 1'b0;
                                    ph       <= low_ph;
                                end
                            end
                        end
                        default: begin
                            // OSC and AFTER_VALID_OSC: timed high window.
                            if (ph != '0) begin
                                ph <= ph - 1'b1;
                            end else if (mode == POL_OSC) begin
                                mode <= cfg_policy;
                                if (skip_low) begin
                                    ph <= high_ph;
                                end else begin
                                    state    <= S_LOW;
                                    s_tready <= 1'b0;
                                    ph       <= low_ph;
                                end
                            end else begin
                                state    <= S_IDLE;
                                s_tready <= 1'b0;
                            end
                        end
                    endcase
                end

                default: begin
                    state    <= S_IDLE;
                    s_tready <= 1'b0;
                end
            endcase
        end
    end

    // Data checker and statistics. A beat coinciding with exp_load is checked
    // against the old expected value; the load then overrides the resync.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            exp_val   <= '0;
            xfer_cnt  <= '0;
            pkt_cnt   <= '0;
            err_cnt   <= '0;
            err_flag  <= 1'b0;
            last_data <= '0;
        end else begin
            if (hs) begin
                last_data <= s_tdata;
                if (xfer_cnt != {CW{1'b1}}) begin
                    xfer_cnt <= xfer_cnt + 1'b1;
                end
                if (s_tlast && (pkt_cnt != {CW{1'b1}})) begin
                    pkt_cnt <= pkt_cnt + 1'b1;
                end
            end
            if (data_err && (err_cnt != {CW{1'b1}})) begin
                err_cnt <= err_cnt + 1'b1;
            end

            if (exp_load) begin
                exp_val  <= exp_seed;
                err_flag <= 1'b0;
            end else begin
                if (hs) begin
                    exp_val <= s_tdata + 1'b1;
                end
                if (data_err) begin
                    err_flag <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi4_stream_ready_sink.sv
// Bench for axi4_stream_ready_sink: directed scenarios with literal
// expectations plus randomized segments checked every cycle against a
// behavioural model of the ready schedule and the data checker.
module tb_axi4_stream_ready_sink;

    localparam int DW   = 8;
    localparam int CW   = 5;
    localparam int TW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          aclk = 1'b0;
    logic          areset;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] s_tdata;
    logic          s_tlast;
    logic [1:0]    cfg_policy;
    logic [TW-1:0] cfg_low;
    logic [TW-1:0] cfg_high;
    logic          exp_load;
    logic [DW-1:0] exp_seed;
    logic [CW-1:0] xfer_cnt;
    logic [CW-1:0] pkt_cnt;
    logic [CW-1:0] err_cnt;
    logic          err_flag;
    logic [DW-1:0] last_data;

    axi4_stream_ready_sink #(.DW(DW), .CW(CW), .TW(TW)) dut (
        .aclk       (aclk),
        .areset     (areset),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tdata    (s_tdata),
        .s_tlast    (s_tlast),
        .cfg_policy (cfg_policy),
        .cfg_low    (cfg_low),
        .cfg_high   (cfg_high),
        .exp_load   (exp_load),
        .exp_seed   (exp_seed),
        .xfer_cnt   (xfer_cnt),
        .pkt_cnt    (pkt_cnt),
        .err_cnt    (err_cnt),
        .err_flag   (err_flag),
        .last_data  (last_data)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Ready is a function of the cycle index t since reset release (cycle 0
    // is the IDLE cycle) and, for event-driven policies, of the times of the
    // last handshake / last valid seen while idle.
    bit            m_on;
    int            mt;
    int            m_pol, m_l, m_h;
    int            m_rf;                 // SINGLE: ready from this cycle on
    int            m_wlo, m_whi, m_idle; // AFTER_VALID_OSC window and idle start
    logic [DW-1:0] m_exp, m_last;
    int            m_xfer, m_pkt, m_err;
    bit            m_flag;

    function automatic bit m_ready(input int c);
        int hh;
        hh = (m_h < 1) ? 1 : m_h;
        case (m_pol)
            0:       return c >= 1;
            1:       return (c >= 1) && (((c - 1) % (m_l + hh)) >= m_l);
            2:       return c >= m_rf;
            default: return (c >= m_wlo) && (c <= m_whi);
        endcase
    endfunction

    task automatic model_reset();
        mt     = 0;
        m_rf   = 1 + m_l;
        m_wlo  = 1;
        m_whi  = 0;
        m_idle = 0;
        m_exp  = '0;
        m_last = '0;
        m_xfer = 0;
        m_pkt  = 0;
        m_err  = 0;
        m_flag = 0;
    endtask

    task automatic model_edge();
        bit hs;
        int hh;
        hh = (m_h < 1) ? 1 : m_h;
        hs = s_tvalid && m_ready(mt);
        if (hs) begin
            if (s_tdata != m_exp) begin
                if (m_err < CMAX) m_err++;
                m_flag = 1;
            end
            m_exp  = s_tdata + 1'b1;
            m_last = s_tdata;
            if (m_xfer < CMAX) m_xfer++;
            if (s_tlast && m_pkt < CMAX) m_pkt++;
        end
        if (exp_load) begin
            m_exp  = exp_seed;
            m_flag = 0;
        end
        if (m_pol == 2 && hs) m_rf = mt + m_l + 1;
        if (m_pol == 3 && mt >= m_idle && s_tvalid) begin
            m_wlo  = mt + m_l + 1;
            m_whi  = mt + m_l + hh;
            m_idle = mt + m_l + hh + 1;
        end
        mt++;
    endtask

    task automatic compare_model();
        chk("ready",     s_tready,  m_ready(mt));
        chk("xfer_cnt",  xfer_cnt,  m_xfer);
        chk("pkt_cnt",   pkt_cnt,   m_pkt);
        chk("err_cnt",   err_cnt,   m_err);
        chk("err_flag",  err_flag,  m_flag);
        chk("last_data", last_data, m_last);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_cfg(input int p, input int l, input int h);
        cfg_policy = p[1:0];
        cfg_low    = l[TW-1:0];
        cfg_high   = h[TW-1:0];
        m_pol = p;
        m_l   = l;
        m_h   = h;
    endtask

    // One clock: model consumes the inputs seen at the edge, outputs are
    // compared 1 time unit later. Returns at posedge+1.
    task automatic step();
        @(posedge aclk);
        if (m_on) model_edge();
        #1;
        if (m_on) compare_model();
    endtask

    task automatic do_reset();
        areset = 1'b1;
        #2;
        chk("rst_ready", s_tready, 0);
        chk("rst_xfer",  xfer_cnt, 0);
        chk("rst_pkt",   pkt_cnt,  0);
        chk("rst_err",   err_cnt,  0);
        chk("rst_flag",  err_flag, 0);
        chk("rst_last",  last_data, 0);
        @(posedge aclk);
        #3;
        areset = 1'b0;
        model_reset();
        if (m_on) compare_model();
    endtask

    logic [DW-1:0] txq[$];

    task automatic send_q();
        int   c;
        logic r;
        for (int i = 0; i < txq.size(); i++) begin
            s_tvalid = 1'b1;
            s_tdata  = txq[i];
            s_tlast  = (i == txq.size() - 1);
            c = 0;
            do begin
                r = s_tready;
                step();
                c++;
            end while (!r && c < 50);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        txq.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          r;
        logic [DW-1:0] src_next;
        logic [7:0]    osc_pat;
        int            viol;
        bit            prev;

        areset = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
        exp_load = 1'b0; exp_seed = '0; m_on = 1;
        set_cfg(0, 0, 0);
        #1;

        // 1: ALWAYS, beats 0..9, last on 9
        do_reset();
        for (int i = 0; i < 10; i++) txq.push_back(i[DW-1:0]);
        send_q();
        chk("t1_xfer", xfer_cnt, 10);
        chk("t1_pkt",  pkt_cnt,  1);
        chk("t1_err",  err_cnt,  0);
        chk("t1_last", last_data, 9);
        chk("t1_ready", s_tready, 1);

        // 2: OSC low=2 high=6, continuous valid -> 0,0,1x6 repeating
        set_cfg(1, 2, 6);
        do_reset();
        osc_pat = 8'hFC;
        s_tvalid = 1'b1; s_tdata = '0;
        for (int k = 1; k <= 25; k++) begin
            r = s_tready;
            step();
            if (r) s_tdata = s_tdata + 1'b1;
            chk("t2_pattern", s_tready, osc_pat[(k - 1) % 8]);
        end
        chk("t2_xfer", xfer_cnt, 18);
        chk("t2_err",  err_cnt,  0);
        s_tvalid = 1'b0;

        // 3: SINGLE low=3, continuous valid -> one handshake per 4 cycles
        set_cfg(2, 3, 0);
        do_reset();
        s_tvalid = 1'b1; s_tdata = '0; viol = 0; prev = 0;
        for (int k = 1; k <= 20; k++) begin
            r = s_tready;
            step();
            if (r) s_tdata = s_tdata + 1'b1;
            if (prev && s_tready) viol++;
            prev = s_tready;
        end
        chk("t3_xfer", xfer_cnt, 4);
        chk("t3_back_to_back", viol, 0);
        s_tvalid = 1'b0;

        // 4: AFTER_VALID_OSC low=2 high=3, valid in cycles 20..25
        set_cfg(3, 2, 3);
        do_reset();
        s_tdata = '0;
        for (int k = 1; k <= 30; k++) begin
            r = s_tready;
            step();
            if (r && s_tvalid) s_tdata = s_tdata + 1'b1;
            s_tvalid = (k >= 20 && k <= 25);
            if (k >= 20) chk("t4_ready", s_tready, (k >= 23 && k <= 25));
        end
        chk("t4_xfer", xfer_cnt, 3);
        s_tvalid = 1'b0;

        // 5: data checking, seed 5 with data 5,6,9,10; wrap cases; load+beat
        set_cfg(0, 0, 0);
        do_reset();
        exp_load = 1'b1; exp_seed = 8'd5;
        step();
        exp_load = 1'b0;
        txq = '{8'd5, 8'd6, 8'd9, 8'd10};
        send_q();
        chk("t5_err",  err_cnt,  1);
        chk("t5_flag", err_flag, 1);
        chk("t5_xfer", xfer_cnt, 4);
        exp_load = 1'b1; exp_seed = 8'h7F;
        step();
        exp_load = 1'b0;
        step();
        chk("t5_flag_cleared", err_flag, 0);
        chk("t5_err_kept",     err_cnt,  1);
        txq = '{8'h7F, 8'h80};
        send_q();
        chk("t5_wrap7f_err", err_cnt, 1);
        exp_load = 1'b1; exp_seed = 8'hFF;
        step();
        exp_load = 1'b0;
        txq = '{8'hFF, 8'h00};
        send_q();
        chk("t5_wrapff_err", err_cnt, 1);
        chk("t5_wrapff_flag", err_flag, 0);
        s_tvalid = 1'b1; s_tdata = 8'h33; exp_load = 1'b1; exp_seed = 8'h40;
        step();
        exp_load = 1'b0; s_tdata = 8'h40;
        step();
        s_tvalid = 1'b0;
        step();
        chk("t5_load_beat_err", err_cnt, 2);
        chk("t5_load_beat_last", last_data, 8'h40);

        // saturation: constant data 0 with tlast on every beat
        do_reset();
        s_tvalid = 1'b1; s_tdata = '0; s_tlast = 1'b1;
        for (int k = 0; k < 40; k++) step();
        s_tvalid = 1'b0; s_tlast = 1'b0;
        step();
        chk("sat_xfer", xfer_cnt, CMAX);
        chk("sat_pkt",  pkt_cnt,  CMAX);
        chk("sat_err",  err_cnt,  CMAX);

        // 6: reset mid-packet while ready is high
        do_reset();
        s_tvalid = 1'b1; s_tdata = '0;
        for (int k = 0; k < 5; k++) begin
            r = s_tready;
            step();
            if (r) s_tdata = s_tdata + 1'b1;
        end
        chk("t6_ready_before", s_tready, 1);
        do_reset();
        s_tvalid = 1'b0;
        step();
        chk("t6_pkt_after", pkt_cnt, 0);

        // policy change ALWAYS -> OSC(low=1, high=2) while in HIGH
        m_on = 0;
        set_cfg(0, 0, 0);
        do_reset();
        for (int k = 0; k < 3; k++) step();
        chk("pc_ready_c3", s_tready, 1);
        set_cfg(1, 1, 2);
        for (int k = 4; k <= 8; k++) begin
            step();
            chk("pc_ready", s_tready, (k == 6 || k == 7));
        end
        m_on = 1;

        // randomized segments
        for (int seg = 0; seg < 30; seg++) begin
            int vprob;
            int ncyc;
            set_cfg($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 5));
            vprob = $urandom_range(30, 100);
            ncyc  = $urandom_range(60, 160);
            do_reset();
            src_next = $urandom;
            for (int k = 0; k < ncyc; k++) begin
                s_tvalid = ($urandom_range(0, 99) < vprob);
                s_tdata  = ($urandom_range(0, 7) == 0) ? DW'($urandom) : src_next;
                s_tlast  = ($urandom_range(0, 3) == 0);
                exp_load = ($urandom_range(0, 24) == 0);
                exp_seed = DW'($urandom);
                r = s_tready;
                if ($urandom_range(0, 399) == 0) begin
                    do_reset();
                end else begin
                    step();
                    if (r && s_tvalid) src_next = s_tdata + 1'b1;
                end
            end
            s_tvalid = 1'b0; s_tlast = 1'b0; exp_load = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
